// File: rtl/inst_rom_pkg.sv
// Shared constants and FSM encoding for the instruction ROM boot loader.
package inst_rom_pkg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    // Byte lane counter width: four bytes per 32-bit word.
    localparam int LANE_W = 2;

    typedef enum logic [2:0] {
        ST_LEN  = 3'd0,
        ST_DATA = 3'd1,
        ST_CSUM = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

endpackage

// File: rtl/inst_rom_word_asm.sv
// Little-endian byte-to-word assembler; emits word_vld with the full word on every 4th byte.
module inst_rom_word_asm
    import inst_rom_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_vld,
    input  logic [7:0]  byte_data,
    output logic        word_vld,
    output logic [31:0] word
);

    localparam logic [LANE_W-1:0] LANE_ONE  = 1;
    localparam logic [LANE_W-1:0] LANE_LAST = '1;

    logic [LANE_W-1:0] lane_q;
    logic [23:0]       shreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q <= '0;
        end else if (byte_vld) begin
            lane_q <= lane_q + LANE_ONE;
        end
    end

    // Newest byte enters at the top so the first byte ends up least significant.
    always_ff @(posedge clk) begin
        if (byte_vld) begin
            shreg <= {byte_data, shreg[23:8]};
        end
    end

    assign word_vld = byte_vld && (lane_q == LANE_LAST);
    assign word     = {byte_data, shreg};

endmodule

// File: rtl/inst_rom_loader.sv
// Instruction memory with byte-serial boot loader holding the core in reset until loaded.
// Optional trailing XOR checksum byte enabled by defining INST_ROM_CHECKSUM_EN.
module inst_rom_loader
    import inst_rom_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_addr_i,
    output logic [31:0] inst_o,
    input  logic        ld_valid_i,
    input  logic [7:0]  ld_data_i,
    output logic        ld_ready_o,
    output logic        cpu_rst_o,
    output logic        load_done_o,
    output logic        load_err_o
);

    localparam int ADDR_W = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_W:0] IDX_ONE = 1;

    state_t          state_q, state_d;
    logic [ADDR_W:0] idx_q, idx_d;
    logic [ADDR_W:0] last_q, last_d;
    logic            accept;
    logic            asm_vld;
    logic [31:0]     asm_word;
    logic            mem_we;
    logic [31:0]     mem [DEPTH_WORDS];

`ifdef INST_ROM_CHECKSUM_EN
    logic [7:0] xor_q, xor_d;
`endif

    assign accept = ld_valid_i && ld_ready_o;

    inst_rom_word_asm u_word_asm (
        .clk       (clk),
        .rst       (rst),
        .byte_vld  (accept),
        .byte_data (ld_data_i),
        .word_vld  (asm_vld),
        .word      (asm_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_LEN;
            idx_q   <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
        end
    end

`ifdef INST_ROM_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            xor_q <= '0;
        end else begin
            xor_q <= xor_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        mem_we  = 1'b0;
`ifdef INST_ROM_CHECKSUM_EN
        xor_d   = xor_q;
`endif
        case (state_q)
            ST_LEN: begin
                // Range check on the full 32-bit count before narrowing it.
                if (asm_vld) begin
                    if (asm_word > 32'(DEPTH_WORDS)) begin
                        state_d = ST_ERR;
                    end else if (asm_word == '0) begin
`ifdef INST_ROM_CHECKSUM_EN
                        state_d = ST_CSUM;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        state_d = ST_DATA;
                        last_d  = asm_word[ADDR_W:0] - IDX_ONE;
                    end
                end
            end
            ST_DATA: begin
`ifdef INST_ROM_CHECKSUM_EN
                if (accept) begin
                    xor_d = xor_q ^ ld_data_i;
                end
`endif
                if (asm_vld) begin
                    mem_we = 1'b1;
                    idx_d  = idx_q + IDX_ONE;
                    if (idx_q == last_q) begin
`ifdef INST_ROM_CHECKSUM_EN
                        state_d = ST_CSUM;
`else
                        state_d = ST_DONE;
`endif
                    end
                end
            end
`ifdef INST_ROM_CHECKSUM_EN
            ST_CSUM: begin
                if (accept) begin
                    state_d = (ld_data_i == xor_q) ? ST_DONE : ST_ERR;
                end
            end
`endif
            ST_DONE: state_d = ST_DONE;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_ERR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx_q[ADDR_W-1:0]] <= asm_word;
        end
    end

    assign ld_ready_o  = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CSUM);
    assign cpu_rst_o   = (state_q != ST_DONE);
    assign load_done_o = (state_q == ST_DONE);
    assign load_err_o  = (state_q == ST_ERR);

    // Byte offset within the word is irrelevant to a word-aligned fetch.
    logic              unused_addr_lsbs;
    logic [ADDR_W-1:0] rd_idx;
    logic              addr_in_range;

    assign unused_addr_lsbs = ^inst_addr_i[1:0];
    assign rd_idx           = inst_addr_i[ADDR_W+1:2];
    assign addr_in_range    = (inst_addr_i[31:ADDR_W+2] == '0);
    assign inst_o           = (load_done_o && addr_in_range) ? mem[rd_idx] : NOP;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Randomized self-checking bench for inst_rom_loader against a stream-level reference model.
module tb_inst_rom_loader;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam logic [31:0] NOP_I = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst_addr = '0;
    logic [31:0] inst;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_data = '0;
    logic        ld_ready, cpu_rst, load_done, load_err;

    always #5 clk = ~clk;

    inst_rom_loader #(.DEPTH_WORDS(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .inst_addr_i (inst_addr),
        .inst_o      (inst),
        .ld_valid_i  (ld_valid),
        .ld_data_i   (ld_data),
        .ld_ready_o  (ld_ready),
        .cpu_rst_o   (cpu_rst),
        .load_done_o (load_done),
        .load_err_o  (load_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] model_mem [DEPTH];
    bit          model_done = 0;
    logic [31:0] img [$];
    logic [7:0]  strm [$];

    function automatic logic [31:0] exp_inst(input logic [31:0] addr);
        if (!model_done || (addr >> (AW + 2)) != 0) return NOP_I;
        return model_mem[(addr >> 2) % DEPTH];
    endfunction

    function automatic void build_stream(input logic [31:0] n, input logic [7:0] corrupt);
        logic [7:0] x;
        logic [7:0] b;
        x = '0;
        strm.delete();
        for (int i = 0; i < 4; i++) strm.push_back(8'(n >> (8 * i)));
        foreach (img[w]) begin
            for (int i = 0; i < 4; i++) begin
                b = 8'(img[w] >> (8 * i));
                x ^= b;
                strm.push_back(b);
            end
        end
`ifdef INST_ROM_CHECKSUM_EN
        strm.push_back(x ^ corrupt);
`else
        if (corrupt != 0) x = '0;
`endif
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        ld_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        model_done = 0;
    endtask

    task automatic play(input int lo, input int hi, input int max_gap);
        for (int k = lo; k < hi; k++) begin
            repeat ($urandom_range(max_gap, 0)) begin
                ld_valid = 1'b0;
                ld_data  = 8'($urandom);
                @(posedge clk); #1;
            end
            ld_valid = 1'b1;
            ld_data  = strm[k];
            n_checks++;
            if (ld_ready !== 1'b1) $display("FAIL ready_byte%0d: got %b want 1", k, ld_ready);
            else n_pass++;
            @(posedge clk); #1;
            ld_valid = 1'b0;
            if (k >= 4 && (k - 4) % 4 == 3 && (k - 4) / 4 < img.size())
                model_mem[(k - 4) / 4] = img[(k - 4) / 4];
        end
    endtask

    task automatic test_reset();
        do_reset();
        repeat (3) begin @(posedge clk); #1; end
        n_checks++;
        if ({cpu_rst, ld_ready, load_done, load_err} !== 4'b1100)
            $display("FAIL reset_ctl: got rst/rdy/done/err=%b want 1100", {cpu_rst, ld_ready, load_done, load_err});
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            inst_addr = (i == 0) ? 32'h0 : $urandom;
            #1;
            n_checks++;
            if (inst !== NOP_I) $display("FAIL reset_inst@%h: got %h want %h", inst_addr, inst, NOP_I);
            else n_pass++;
        end
    endtask

    task automatic test_image(input int max_gap);
        logic [31:0] want;
        do_reset();
        img = '{32'h0050_0093, 32'h0010_8113};
        build_stream(32'd2, 8'h00);
        play(0, strm.size() - 1, max_gap);
        n_checks++;
        if (load_done !== 1'b0 || cpu_rst !== 1'b1)
            $display("FAIL image_early_done gap%0d: got done=%b cpu_rst=%b want 0/1", max_gap, load_done, cpu_rst);
        else n_pass++;
        play(strm.size() - 1, strm.size(), max_gap);
        model_done = 1;
        n_checks++;
        if ({load_done, cpu_rst, ld_ready, load_err} !== 4'b1000)
            $display("FAIL image_release gap%0d: got done/rst/rdy/err=%b want 1000", max_gap, {load_done, cpu_rst, ld_ready, load_err});
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            inst_addr = (i == 0) ? 32'd0 : (i == 1) ? 32'd4 : 32'd6;
            want = (i == 0) ? 32'h0050_0093 : 32'h0010_8113;
            #1;
            n_checks++;
            if (inst !== want) $display("FAIL image_read gap%0d @%0d: got %h want %h", max_gap, inst_addr, inst, want);
            else n_pass++;
        end
        // Data presented after completion must be ignored.
        ld_valid = 1'b1; ld_data = 8'hff;
        repeat (3) begin @(posedge clk); #1; end
        ld_valid = 1'b0;
        inst_addr = 32'd4; #1;
        n_checks++;
        if (inst !== 32'h0010_8113 || load_done !== 1'b1)
            $display("FAIL image_hold gap%0d: got %h done=%b want 00108113 done=1", max_gap, inst, load_done);
        else n_pass++;
    endtask

    task automatic test_overrange();
        logic [31:0] bad [2];
        bad[0] = 32'(DEPTH + 1);
        bad[1] = 32'h8000_0000 | 32'(DEPTH);
        for (int t = 0; t < 2; t++) begin
            do_reset();
            img.delete();
            build_stream(bad[t], 8'h00);
            play(0, 3, 2);
            n_checks++;
            if (load_err !== 1'b0 || ld_ready !== 1'b1)
                $display("FAIL ovr_early n=%h: got err=%b rdy=%b want 0/1", bad[t], load_err, ld_ready);
            else n_pass++;
            play(3, 4, 2);
            n_checks++;
            if ({load_err, ld_ready, cpu_rst, load_done} !== 4'b1010)
                $display("FAIL ovr_err n=%h: got err/rdy/rst/done=%b want 1010", bad[t], {load_err, ld_ready, cpu_rst, load_done});
            else n_pass++;
            ld_valid = 1'b1;
            repeat (5) begin ld_data = 8'($urandom); @(posedge clk); #1; end
            ld_valid = 1'b0;
            inst_addr = 32'd0; #1;
            n_checks++;
            if (load_err !== 1'b1 || cpu_rst !== 1'b1 || inst !== NOP_I)
                $display("FAIL ovr_sticky n=%h: got err=%b rst=%b inst=%h want 1/1/%h", bad[t], load_err, cpu_rst, inst, NOP_I);
            else n_pass++;
        end
        do_reset();
        n_checks++;
        if (load_err !== 1'b0 || ld_ready !== 1'b1)
            $display("FAIL ovr_clear: got err=%b rdy=%b want 0/1", load_err, ld_ready);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        img = '{$urandom, $urandom, $urandom};
        build_stream(32'd3, 8'h00);
        play(0, 9, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        inst_addr = 32'd0; #1;
        n_checks++;
        if ({cpu_rst, load_done, ld_ready} !== 3'b101 || inst !== NOP_I)
            $display("FAIL mid_reset: got rst/done/rdy=%b inst=%h want 101 %h", {cpu_rst, load_done, ld_ready}, inst, NOP_I);
        else n_pass++;
        img = '{$urandom, $urandom, $urandom};
        build_stream(32'd3, 8'h00);
        play(0, strm.size() - 1, 2);
        n_checks++;
        if (load_done !== 1'b0) $display("FAIL mid_early_done: got %b want 0", load_done);
        else n_pass++;
        play(strm.size() - 1, strm.size(), 2);
        model_done = 1;
        n_checks++;
        if (load_done !== 1'b1) $display("FAIL mid_done: got %b want 1", load_done);
        else n_pass++;
        for (int w = 0; w < 3; w++) begin
            inst_addr = 32'(w * 4) | 32'($urandom_range(3, 0)); #1;
            n_checks++;
            if (inst !== img[w]) $display("FAIL mid_read w%0d: got %h want %h", w, inst, img[w]);
            else n_pass++;
        end
    endtask

    task automatic test_full_depth();
        logic [31:0] a;
        do_reset();
        img.delete();
        for (int w = 0; w < DEPTH; w++) img.push_back($urandom);
        build_stream(32'(DEPTH), 8'h00);
        play(0, strm.size(), 1);
        model_done = 1;
        n_checks++;
        if (load_done !== 1'b1 || load_err !== 1'b0)
            $display("FAIL full_done: got done=%b err=%b want 1/0", load_done, load_err);
        else n_pass++;
        for (int i = 0; i < 24; i++) begin
            a = (i < 20) ? 32'($urandom_range(4 * DEPTH - 1, 0)) : ($urandom | (32'd1 << (AW + 2)));
            inst_addr = a; #1;
            n_checks++;
            if (inst !== exp_inst(a)) $display("FAIL full_read @%h: got %h want %h", a, inst, exp_inst(a));
            else n_pass++;
        end
    endtask

    task automatic test_zero_count();
        logic [31:0] a;
        do_reset();
        img.delete();
        build_stream(32'd0, 8'h00);
        play(0, strm.size(), 0);
        model_done = 1;
        n_checks++;
        if (load_done !== 1'b1 || cpu_rst !== 1'b0)
            $display("FAIL zero_done: got done=%b rst=%b want 1/0", load_done, cpu_rst);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            a = 32'($urandom_range(4 * DEPTH - 1, 0));
            inst_addr = a; #1;
            n_checks++;
            if (inst !== exp_inst(a)) $display("FAIL zero_read @%h: got %h want %h", a, inst, exp_inst(a));
            else n_pass++;
        end
    endtask

`ifdef INST_ROM_CHECKSUM_EN
    task automatic test_csum_err();
        do_reset();
        img = '{$urandom, $urandom};
        build_stream(32'd2, 8'h01);
        play(0, strm.size(), 1);
        inst_addr = 32'd0; #1;
        n_checks++;
        if ({load_err, load_done, cpu_rst, ld_ready} !== 4'b1010 || inst !== NOP_I)
            $display("FAIL csum_err: got err/done/rst/rdy=%b inst=%h want 1010 %h", {load_err, load_done, cpu_rst, ld_ready}, inst, NOP_I);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_image(0);
        test_overrange();
        test_image(5);
        test_reset_mid();
        test_full_depth();
        test_zero_count();
`ifdef INST_ROM_CHECKSUM_EN
        test_csum_err();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
